serial_add_datapath: RTL and testbench
======================================

// Module: serial_add_datapath
// PURPOSE
// - Bit-serial adder datapath; the responder to the serial-adder FSM controller.
// - Decodes the controller's STATE[1:0] and loads A/B. Adds LSB-first, one bit per clk.
// - Returns counterflag to the controller after WIDTH bit-times.
// - Presents the parallel sum and carry-out until the next load.
// PARAMETERS
// - WIDTH  8  operand/sum width in bits (>=2); counter is $clog2(WIDTH+1) bits
// PORTS
// - clk          in   1      single clock; all state updates on rising edge
// - rst          in   1      asynchronous, active-low reset (0 = reset)
// - STATE        in   2      controller state: 00 IDLE, 01 LOAD, 10 ADD, 11 DONE
// - a_in         in   WIDTH  operand A, sampled in LOAD
// - b_in         in   WIDTH  operand B, sampled in LOAD
// - cin          in   1      carry-in, sampled in LOAD
// - counterflag  out  1      registered; 1 = WIDTH bits have been added
// - sum_bit      out  1      combinational current sum bit (a_sh[0]^b_sh[0]^carry)
// - sum_out      out  WIDTH  registered parallel sum (sum shift register)
// - cout         out  1      registered carry flip-flop (final carry-out once counterflag=1)
// BEHAVIOUR
// - Reset (rst=0, async): a_sh, b_sh, sum_sh, carry, count, counterflag all 0.
//   - Therefore sum_out=0, cout=0, counterflag=0, sum_bit=0.
//   - Reset mid-ADD aborts; no partial result is retained.
// - IDLE (00): all registers hold.
// - LOAD (01), one edge:
//   - a_sh<=a_in, b_sh<=b_in, carry<=cin, sum_sh<=0, count<=0, counterflag<=0.
//   - A LOAD during ADD or DONE restarts the operation. No error flag is raised.
// - ADD (10), per edge while count<WIDTH:
//   - s = a_sh[0]^b_sh[0]^carry
//   - carry <= majority(a_sh[0], b_sh[0], carry)
//   - a_sh,b_sh >> 1 (zero fill)
//   - sum_sh <= {s, sum_sh[WIDTH-1:1]}
//   - count <= count+1
//   - counterflag <= (count==WIDTH-1)
// - ADD with count==WIDTH: saturate. No shift, no carry update, and counterflag stays 1.
//   Extra ADD cycles never corrupt the result.
// - Latency: counterflag rises on the WIDTH-th ADD edge (WIDTH cycles after the LOAD edge
//   when ADD is continuous). sum_out and cout are final on that same edge.
// - ADD cycles need not be contiguous. IDLE between ADD cycles pauses the operation.
// - DONE (11): all registers hold; sum_out/cout stable until next LOAD or reset.
// - Arithmetic: unsigned modulo 2^WIDTH. {cout,sum_out} = a_in + b_in + cin
//   (WIDTH+1 bits exact).
// - Handshake with controller: the controller leaves ADD only after sampling counterflag=1.
//   The datapath does not require this (see saturation).
// - STATE is treated as synchronous to clk. No input registering, zero decode latency.
// CONFIGURATION
// - SIGNED_OVF_EN defined:
//   - Adds output port ovf (out, 1, registered).
//   - On the WIDTH-th ADD edge, ovf <= carry_into_msb ^ carry_out_of_msb
//     (two's-complement overflow).
//   - Cleared by reset and LOAD. Held otherwise, including during saturated ADD.
// - SIGNED_OVF_EN undefined: no ovf port, no related logic; behaviour otherwise identical.
// TESTING
// - WIDTH=8, rst low 100ns then high. LOAD a=0x35 b=0x4A cin=0, then 8 ADD cycles
//   -> sum_out=0x7F, cout=0. counterflag=0 after edges 1-7; 1 after edge 8.
// - LOAD a=0xFF b=0x01 cin=0, 8 ADD -> sum_out=0x00, cout=1.
//   Then 5 further ADD cycles -> sum_out=0x00, cout=1, counterflag=1 unchanged.
// - LOAD a=0xFF b=0x00 cin=1, ADD interleaved with IDLE (ADD,IDLE,ADD,...) -> after 8th ADD
//   sum_out=0x00, cout=1. counterflag=1 only after the 8th ADD edge.
// - LOAD a=0x12 b=0x34, 3 ADD, drop rst for 1 cycle -> all outputs 0 immediately
//   (before next clk edge). Then LOAD 0x12/0x34, 8 ADD -> sum_out=0x46.
// - LOAD a=0x10 b=0x10, 4 ADD, LOAD a=0x01 b=0x02 cin=1 -> counterflag=0, count restarts.
//   8 ADD -> sum_out=0x04, cout=0. DONE holds 0x04 for 10 cycles.
// - SIGNED_OVF_EN: 0x7F+0x01 -> sum_out=0x80, ovf=1. 0x80+0x80 -> sum_out=0x00, cout=1, ovf=1.
//   0xFF+0x01 -> ovf=0.

Source files
------------

// File: rtl/serial_add_datapath.sv
// serial_add_datapath
//   Bit-serial adder datapath driven by an external controller through STATE.
//   Operands are loaded in parallel and added LSB-first, one bit per clock;
//   counterflag tells the controller when all WIDTH bits have been added.
//   The parallel sum and carry-out stay on the outputs until the next load.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   STATE        in   2'b00 IDLE, 2'b01 LOAD, 2'b10 ADD, 2'b11 DONE
//   a_in, b_in   in   WIDTH-bit operands, sampled in LOAD
//   cin          in   carry-in, sampled in LOAD
//   counterflag  out  registered, 1 once WIDTH bits have been added
//   sum_bit      out  combinational sum of the current bit position
//   sum_out      out  registered parallel sum
//   cout         out  registered carry (final carry-out once counterflag=1)
//   ovf          out  (only with SIGNED_OVF_EN) registered two's-complement overflow
//
// Configuration
//   `define SIGNED_OVF_EN to add the ovf port and its logic.
module serial_add_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       STATE,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             counterflag,
    output logic             sum_bit,
    output logic [WIDTH-1:0] sum_out,
`ifdef SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_ADD  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t st;
    assign st = state_t'(STATE);

    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic             cflag_q, cflag_d;
    logic             s;
    logic             maj;

    // Full adder on the current LSBs
    assign s   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign maj = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

`ifdef SIGNED_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        count_d  = count_q;
        cflag_d  = cflag_q;
`ifdef SIGNED_OVF_EN
        ovf_d    = ovf_q;
`endif
        unique case (st)
            ST_LOAD: begin
                a_sh_d   = a_in;
                b_sh_d   = b_in;
                carry_d  = cin;
                sum_sh_d = '0;
                count_d  = '0;
                cflag_d  = 1'b0;
`ifdef SIGNED_OVF_EN
                ovf_d    = 1'b0;
`endif
            end
            ST_ADD: begin
                // Once WIDTH bits are done everything holds, so extra ADD
                // cycles leave the result untouched.
                if (count_q < CNT_MAX) begin
                    carry_d  = maj;
                    a_sh_d   = a_sh_q >> 1;
                    b_sh_d   = b_sh_q >> 1;
                    sum_sh_d = {s, sum_sh_q[WIDTH-1:1]};
                    count_d  = count_q + 1'b1;
                    cflag_d  = (count_q == CNT_LAST);
`ifdef SIGNED_OVF_EN
                    // On the MSB step carry_q is the carry into the MSB and
                    // maj the carry out of it.
                    if (count_q == CNT_LAST) ovf_d = carry_q ^ maj;
`endif
                end
            end
            default: ; // IDLE and DONE hold all state
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            cflag_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            cflag_q  <= cflag_d;
`ifdef SIGNED_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign sum_bit     = s;
    assign sum_out     = sum_sh_q;
    assign cout        = carry_q;
    assign counterflag = cflag_q;
`ifdef SIGNED_OVF_EN
    assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_datapath.sv
// Testbench for serial_add_datapath: directed scenarios plus random STATE
// sequences, checked through a scoreboard queue against an arithmetic model.
module tb_serial_add_datapath;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   STATE = 2'b00;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         counterflag;
    logic         sum_bit;
    logic [W-1:0] sum_out;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

`ifndef SIGNED_OVF_EN
    assign ovf = 1'b0;
`endif

    serial_add_datapath #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .STATE       (STATE),
        .a_in        (a_in),
        .b_in        (b_in),
        .cin         (cin),
        .counterflag (counterflag),
        .sum_bit     (sum_bit),
        .sum_out     (sum_out),
`ifdef SIGNED_OVF_EN
        .ovf         (ovf),
`endif
        .cout        (cout)
    );

    // kind 0: full model check, 1: constant sum/cout/counterflag, 2: constant ovf
    typedef struct {
        string        name;
        int           kind;
        logic [W-1:0] sum;
        logic         co;
        logic         cf;
        logic         sb;
        logic         ov;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference: operands of the last load and number of bits added so far.
    int unsigned ma = 0, mb = 0, mc = 0, mk = 0;

    function automatic exp_t model(input string nm);
        exp_t e;
        int unsigned full, mask, part;
        int sa, sb2, sr;
        full   = ma + mb + mc;
        mask   = (32'd1 << mk) - 1;
        part   = full & mask;
        e.name = nm;
        e.kind = 0;
        // Low mk bits of the true sum, shifted in from the top
        e.sum  = W'(part << (W - mk));
        e.co   = 1'(((ma & mask) + (mb & mask) + mc) >> mk);
        e.cf   = (mk == W);
        e.sb   = 1'(full >> mk);
        sa     = (ma >= 128) ? int'(ma) - 256 : int'(ma);
        sb2    = (mb >= 128) ? int'(mb) - 256 : int'(mb);
        sr     = sa + sb2 + int'(mc);
        e.ov   = (mk == W) && (sr > 127 || sr < -128);
        return e;
    endfunction

    task automatic expc(input string nm, input logic [W-1:0] s, input logic co, input logic cf);
        exp_t e;
        e = '{name: nm, kind: 1, sum: s, co: co, cf: cf, sb: 1'b0, ov: 1'b0};
        q.push_back(e);
    endtask

    task automatic expov(input string nm, input logic ov);
        exp_t e;
        e = '{name: nm, kind: 2, sum: '0, co: 1'b0, cf: 1'b0, sb: 1'b0, ov: ov};
        q.push_back(e);
    endtask

    task automatic step(input logic [1:0] st, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input string nm);
        STATE = st;
        a_in  = a;
        b_in  = b;
        cin   = c;
        @(posedge clk);
        if (st == 2'b01) begin
            ma = a; mb = b; mc = c; mk = 0;
        end else if (st == 2'b10 && mk < W) begin
            mk++;
        end
        #1 q.push_back(model(nm));
    endtask

    task automatic adds(input int n, input string nm);
        for (int i = 0; i < n; i++) step(2'b10, '0, '0, 1'b0, nm);
    endtask

    task automatic pulse_reset(input string nm);
        STATE = 2'b00;
        @(posedge clk);
        #2 rst = 1'b0;
        ma = 0; mb = 0; mc = 0; mk = 0;
        #1 q.push_back(model(nm));
        expc({nm, "_const"}, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic cmp(input string nm, input string f, input logic [W-1:0] act, input logic [W-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", nm, f, act, want);
        end
    endtask

    // Monitor: outputs are stable at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.kind == 0) begin
                    cmp(e.name, "sum_out", sum_out, e.sum);
                    cmp(e.name, "cout", W'(cout), W'(e.co));
                    cmp(e.name, "counterflag", W'(counterflag), W'(e.cf));
                    cmp(e.name, "sum_bit", W'(sum_bit), W'(e.sb));
`ifdef SIGNED_OVF_EN
                    cmp(e.name, "ovf", W'(ovf), W'(e.ov));
`endif
                end else if (e.kind == 1) begin
                    cmp(e.name, "sum_out", sum_out, e.sum);
                    cmp(e.name, "cout", W'(cout), W'(e.co));
                    cmp(e.name, "counterflag", W'(counterflag), W'(e.cf));
                end else begin
                    cmp(e.name, "ovf", W'(ovf), W'(e.ov));
                end
            end
        end
    end

    initial begin
        int unsigned r;
        #2 q.push_back(model("reset"));
        expc("reset_const", '0, 1'b0, 1'b0);
        #98 rst = 1'b1;

        step(2'b01, 8'h35, 8'h4A, 1'b0, "t1_load");
        adds(8, "t1_add");
        expc("t1_final", 8'h7F, 1'b0, 1'b1);

        step(2'b01, 8'hFF, 8'h01, 1'b0, "t2_load");
        adds(8, "t2_add");
        expc("t2_final", 8'h00, 1'b1, 1'b1);
        adds(5, "t2_sat");
        expc("t2_sat_final", 8'h00, 1'b1, 1'b1);

        step(2'b01, 8'hFF, 8'h00, 1'b1, "t3_load");
        for (int i = 0; i < 8; i++) begin
            step(2'b10, '0, '0, 1'b0, "t3_add");
            step(2'b00, '0, '0, 1'b0, "t3_idle");
        end
        expc("t3_final", 8'h00, 1'b1, 1'b1);

        step(2'b01, 8'h12, 8'h34, 1'b0, "t4_load");
        adds(3, "t4_add");
        pulse_reset("t4_reset");
        step(2'b01, 8'h12, 8'h34, 1'b0, "t4_reload");
        adds(8, "t4_add2");
        expc("t4_final", 8'h46, 1'b0, 1'b1);

        step(2'b01, 8'h10, 8'h10, 1'b0, "t5_load");
        adds(4, "t5_add");
        step(2'b01, 8'h01, 8'h02, 1'b1, "t5_restart");
        expc("t5_restart_const", 8'h00, 1'b1, 1'b0);
        adds(8, "t5_add2");
        expc("t5_final", 8'h04, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(2'b11, '0, '0, 1'b0, "t5_done");
        expc("t5_done_hold", 8'h04, 1'b0, 1'b1);

`ifdef SIGNED_OVF_EN
        step(2'b01, 8'h7F, 8'h01, 1'b0, "ov1_load");
        adds(8, "ov1_add");
        expc("ov1_final", 8'h80, 1'b0, 1'b1);
        expov("ov1_ovf", 1'b1);
        step(2'b01, 8'h80, 8'h80, 1'b0, "ov2_load");
        adds(8, "ov2_add");
        expc("ov2_final", 8'h00, 1'b1, 1'b1);
        expov("ov2_ovf", 1'b1);
        adds(3, "ov2_sat");
        expov("ov2_sat_ovf", 1'b1);
        step(2'b01, 8'hFF, 8'h01, 1'b0, "ov3_load");
        adds(8, "ov3_add");
        expov("ov3_ovf", 1'b0);
`endif

        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0)
                pulse_reset("rnd_reset");
            else if (r <= 3)
                step(2'b01, W'($urandom), W'($urandom), 1'($urandom), "rnd_load");
            else if (r <= 6)
                step(2'b00, W'($urandom), W'($urandom), 1'($urandom), "rnd_idle");
            else if (r <= 8)
                step(2'b11, W'($urandom), W'($urandom), 1'($urandom), "rnd_done");
            else
                step(2'b10, W'($urandom), W'($urandom), 1'($urandom), "rnd_add");
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
